alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked integer ALU for the execute stage of the RV32 core. It extends the team's combinational 3-bit-opcode ALU in four ways: configurable width, a full RV32I op set with status flags, a registered output behind a valid/ready handshake, and an optional area-saving serial shifter that makes shifts multi-cycle.

## Interface
Parameters:
- XLEN, 32: operand/result width; must be a power of two, at least 8.
- SERIAL_SHIFT, 0: 0 selects a single-cycle barrel shifter; 1 selects a 1-bit-per-cycle iterative shifter.

Ports (SW = $clog2(XLEN)):
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- in_a  in  XLEN  operand A.
- in_b  in  XLEN  operand B; shift amount is in_b[SW-1:0].
- in_op  in  4  opcode: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SRL, 6 SLL, 7 SRA, 8 SLT, 9 SLTU, 10–15 reserved.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer accepts the result this cycle.
- out_result  out  XLEN  result.
- out_zero  out  1  out_result == 0.
- out_carry  out  1  ADD: carry-out of bit XLEN-1. SUB: borrow, i.e. A <u B. All other ops: 0.
- out_overflow  out  1  ADD/SUB signed overflow; all other ops: 0.

## Operation
- Accept: a request is accepted on a rising edge where in_valid && in_ready.
- Output drain: the result is consumed on a rising edge where out_valid && out_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready). Accept and drain may occur on the same edge; the new result replaces the old one.
- Arithmetic:
  - ADD/SUB use a single XLEN+1-bit adder computing A + (sub ? ~B : B) + sub.
  - Overflow: operand sign bits (with B inverted for SUB) agree and the result sign differs.
- SLT/SLTU: result is {XLEN-1 zeros, cmp}. SLT compares signed; SLTU compares unsigned.
- Shifts:
  - SRL and SLL fill with zeros; SRA fills with A[XLEN-1].
  - Only the low SW bits of B are used; upper bits are ignored.
- Reserved opcodes: result 0, out_zero = 1, out_carry = 0, out_overflow = 0. No error is signalled.
- Flags are computed from the same operation as the result and registered together with it.
- State machine (IDLE, SHIFT). SHIFT exists only when SERIAL_SHIFT = 1.
  - IDLE → SHIFT: a shift op is accepted with shamt != 0. The working register is loaded with A, the count with shamt, and the op type is latched.
  - SHIFT: each cycle the working register shifts by one bit and the count decrements.
  - SHIFT → IDLE: when the count reaches 0, the result and flags load into the output register and out_valid sets.
  - Shifts with shamt = 0 and all non-shift ops complete directly from IDLE.
  - When SERIAL_SHIFT = 0, the block stays in IDLE.
- On entry to SHIFT the output register is always empty (guaranteed by the in_ready rule), so completion never stalls.
- Output stability: while out_valid && !out_ready, out_result and all flags hold stable.

## Timing
- Reset values: out_valid = 0, out_result = 0, all flags = 0, state = IDLE.
  - in_ready = 1 in the cycle after the reset edge, provided rst is low.
- Reset asserted mid-SHIFT or with a held result: the operation is discarded and no result is produced.
- Latency, non-serial ops: accept at edge E puts out_valid high in the cycle after E.
- Throughput: one op per cycle while out_ready = 1.
- Serial shift with shamt = n > 0: accept at edge E puts out_valid high n cycles after the cycle following E.
  - in_ready is 0 for those n cycles.
- in_* values are sampled only at the accept edge; changes at other times have no effect.
- No combinational path from in_* to out_*. in_ready depends combinationally on out_ready.

## Test plan
- ADD, XLEN=32: A=0x7FFFFFFF, B=1 → result 0x80000000, overflow=1, carry=0, zero=0. A=0xFFFFFFFF, B=1 → result 0, carry=1, zero=1.
- SUB/compare: A=5, B=7, SUB → 0xFFFFFFFE, carry=1, overflow=0. SLT(0xFFFFFFFF, 1) → 1. SLTU(0xFFFFFFFF, 1) → 0.
- Shifts, both SERIAL_SHIFT values: SRA(0x80000000, B=0x24) → 0xF8000000 (shamt 4, upper B bits ignored). SRL of the same → 0x08000000. SLL(1, 31) → 0x80000000.
- Serial latency, SERIAL_SHIFT=1: SLL with shamt 5 accepted at edge E → in_ready low for 5 cycles, out_valid high 6 cycles after E. shamt 0 → 1-cycle latency.
- Backpressure: back-to-back ADDs with out_ready held low for 3 cycles → first result held stable, in_ready=0, no request lost or duplicated. Then a burst with out_ready=1 → one result per cycle, in order.
- Reset mid-SHIFT: rst pulsed 2 cycles into a shamt-20 shift → out_valid never rises for that op, and all outputs read 0 after reset. The next ADD(2, 3) returns 5 with 1-cycle latency.

Source files
------------

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked integer ALU with registered result/flags and optional serial shifter
module alu_pipe #(
    parameter int XLEN         = 32,
    parameter int SERIAL_SHIFT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [3:0]      in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_carry,
    output logic            out_overflow
);
    localparam int SW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_work;
    logic [SW-1:0]   r_cnt;
    logic [1:0]      r_sop;      // in_op[1:0] of the shift: 01 SRL, 10 SLL, 11 SRA
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_carry;
    logic            r_ovf;

    logic            w_accept;
    logic            w_drain;
    logic            w_is_shift;
    logic            w_go_shift;
    logic            w_shift_done;
    logic [SW-1:0]   w_shamt;
    logic            w_sub;
    logic [XLEN-1:0] w_b_eff;
    logic [XLEN:0]   w_sum;
    logic            w_add_ovf;
    logic [XLEN-1:0] w_srl;
    logic [XLEN-1:0] w_sll;
    logic [XLEN-1:0] w_sra;
    logic [XLEN-1:0] w_res;
    logic            w_carry;
    logic            w_ovf;
    logic [XLEN-1:0] w_step;

    assign in_ready     = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept     = in_valid && in_ready;
    assign w_drain      = r_out_valid && out_ready;
    assign w_shamt      = in_b[SW-1:0];
    assign w_is_shift   = (in_op == OP_SRL) || (in_op == OP_SLL) || (in_op == OP_SRA);
    // Zero-distance shifts finish from IDLE even in serial mode.
    assign w_go_shift   = (SERIAL_SHIFT != 0) && w_is_shift && (w_shamt != '0);
    assign w_shift_done = (r_state == S_SHIFT) && (r_cnt == SW'(1));

    // One shared adder; SUB is A + ~B + 1, so the carry-out is the inverse of the borrow.
    assign w_sub     = (in_op == OP_SUB);
    assign w_b_eff   = w_sub ? ~in_b : in_b;
    assign w_sum     = {1'b0, in_a} + {1'b0, w_b_eff} + {{XLEN{1'b0}}, w_sub};
    assign w_add_ovf = (in_a[XLEN-1] == w_b_eff[XLEN-1]) && (w_sum[XLEN-1] != in_a[XLEN-1]);

    generate
        if (SERIAL_SHIFT == 0) begin : g_barrel
            assign w_srl = in_a >> w_shamt;
            assign w_sll = in_a << w_shamt;
            assign w_sra = XLEN'($signed(in_a) >>> w_shamt);
        end else begin : g_serial
            // Only shamt == 0 completes from IDLE here, so the result is A itself.
            assign w_srl = in_a;
            assign w_sll = in_a;
            assign w_sra = in_a;
        end
    endgenerate

    // Single-cycle result and flags for ops that complete from IDLE
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (in_op)
            OP_ADD:  begin w_res = w_sum[XLEN-1:0]; w_carry = w_sum[XLEN];  w_ovf = w_add_ovf; end
            OP_SUB:  begin w_res = w_sum[XLEN-1:0]; w_carry = !w_sum[XLEN]; w_ovf = w_add_ovf; end
            OP_XOR:  w_res = in_a ^ in_b;
            OP_OR:   w_res = in_a | in_b;
            OP_AND:  w_res = in_a & in_b;
            OP_SRL:  w_res = w_srl;
            OP_SLL:  w_res = w_sll;
            OP_SRA:  w_res = w_sra;
            OP_SLT:  w_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU: w_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            default: w_res = '0;
        endcase
    end

    // One-bit step of the iterative shifter
    always_comb begin
        w_step = r_work;
        case (r_sop)
            2'b01:   w_step = {1'b0, r_work[XLEN-1:1]};
            2'b10:   w_step = {r_work[XLEN-2:0], 1'b0};
            2'b11:   w_step = {r_work[XLEN-1], r_work[XLEN-1:1]};
            default: w_step = r_work;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state: enter SHIFT on a nonzero serial shift, leave when the last step is taken
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_go_shift) w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_cnt == SW'(1))        w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Serial shifter working register and remaining-step count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work <= '0;
            r_cnt  <= '0;
            r_sop  <= '0;
        end else if (w_accept && w_go_shift) begin
            r_work <= in_a;
            r_cnt  <= w_shamt;
            r_sop  <= in_op[1:0];
        end else if (r_state == S_SHIFT) begin
            r_work <= w_step;
            r_cnt  <= r_cnt - SW'(1);
        end
    end

    // Output register: load on direct completion or final shift step, clear valid on drain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_accept && !w_go_shift) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_zero      <= (w_res == '0);
            r_carry     <= w_carry;
            r_ovf       <= w_ovf;
        end else if (w_shift_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_step;
            r_zero      <= (w_step == '0);
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_result   = r_result;
    assign out_zero     = r_zero;
    assign out_carry    = r_carry;
    assign out_overflow = r_ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - bench for alu_pipe, barrel (dut 0) and serial (dut 1) shifter builds
module tb_alu_pipe;
    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       in_valid;
    logic [1:0]       out_ready;
    logic [1:0][31:0] in_a;
    logic [1:0][31:0] in_b;
    logic [1:0][3:0]  in_op;
    wire  [1:0]       in_ready;
    wire  [1:0]       out_valid;
    wire  [1:0]       out_zero;
    wire  [1:0]       out_carry;
    wire  [1:0]       out_overflow;
    wire  [1:0][31:0] out_result;

    int n_total = 0;
    int n_bad   = 0;
    logic [34:0] q0[$];
    logic [34:0] q1[$];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [2:0]  f;   // {zero, carry, overflow}
    } vec_t;

    always #5 clk = ~clk;

    alu_pipe #(.XLEN(32), .SERIAL_SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_op(in_op[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_result(out_result[0]), .out_zero(out_zero[0]),
        .out_carry(out_carry[0]), .out_overflow(out_overflow[0])
    );

    alu_pipe #(.XLEN(32), .SERIAL_SHIFT(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_op(in_op[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_result(out_result[1]), .out_zero(out_zero[1]),
        .out_carry(out_carry[1]), .out_overflow(out_overflow[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: results from plain integer arithmetic; overflow means the true
    // signed result does not survive truncation to 32 bits.
    function automatic logic [34:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, s;
        logic [32:0] u;
        logic [31:0] r;
        logic c, v;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        r = '0; c = 1'b0; v = 1'b0; s = 0;
        case (op)
            4'd0: begin u = {1'b0, a} + {1'b0, b}; r = u[31:0]; c = u[32]; s = sa + sb;
                        v = (s != longint'($signed(r))); end
            4'd1: begin r = a - b; c = (a < b); s = sa - sb; v = (s != longint'($signed(r))); end
            4'd2: r = a ^ b;
            4'd3: r = a | b;
            4'd4: r = a & b;
            4'd5: r = a >> sh;
            4'd6: r = a << sh;
            4'd7: r = 32'($signed(a) >>> sh);
            4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return {r, (r == 32'd0), c, v};
    endfunction

    function automatic vec_t get_vec(input int i);
        case (i)
            0:  return '{4'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 3'b001};
            1:  return '{4'd0,  32'hFFFFFFFF, 32'h1,        32'h00000000, 3'b110};
            2:  return '{4'd1,  32'h5,        32'h7,        32'hFFFFFFFE, 3'b010};
            3:  return '{4'd8,  32'hFFFFFFFF, 32'h1,        32'h00000001, 3'b000};
            4:  return '{4'd9,  32'hFFFFFFFF, 32'h1,        32'h00000000, 3'b100};
            5:  return '{4'd7,  32'h80000000, 32'h24,       32'hF8000000, 3'b000};
            6:  return '{4'd5,  32'h80000000, 32'h24,       32'h08000000, 3'b000};
            7:  return '{4'd6,  32'h1,        32'h1F,       32'h80000000, 3'b000};
            8:  return '{4'd6,  32'h1,        32'h5,        32'h00000020, 3'b000};
            9:  return '{4'd6,  32'h3,        32'h0,        32'h00000003, 3'b000};
            10: return '{4'd12, 32'd123,      32'd456,      32'h00000000, 3'b100};
            11: return '{4'd7,  32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000};
            default: return '{4'd1, 32'h80000000, 32'h1,    32'h7FFFFFFF, 3'b001};
        endcase
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            4: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op on dut d with out_ready high; report result, flags, latency and in_ready-low cycles.
    task automatic run_op(input int d, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [2:0] flg, output int lat, output int nlow);
        @(negedge clk);
        in_valid[d] = 1'b1; in_op[d] = op; in_a[d] = a; in_b[d] = b; out_ready[d] = 1'b1;
        #1;
        for (int t = 0; t < 50 && !in_ready[d]; t++) begin
            @(negedge clk); #1;
        end
        chk("run_in_ready", in_ready[d], 1);
        @(negedge clk);
        in_valid[d] = 1'b0;
        #1;
        lat = 1; nlow = 0;
        while (!out_valid[d] && lat < 60) begin
            if (!in_ready[d]) nlow++;
            @(negedge clk); #1;
            lat++;
        end
        res = out_result[d];
        flg = {out_zero[d], out_carry[d], out_overflow[d]};
    endtask

    task automatic rand_phase(input int ncyc, input int ndrain);
        logic [34:0]      got, exp;
        logic [1:0]       held;
        logic [1:0][34:0] held_val;
        int               sz;
        held = '0;
        held_val = '0;
        for (int c = 0; c < ncyc + ndrain; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (c < ncyc) begin
                    in_valid[d]  = ($urandom_range(0, 3) != 0);
                    in_op[d]     = 4'($urandom_range(0, 11));
                    in_a[d]      = pick_val();
                    in_b[d]      = pick_val();
                    out_ready[d] = ($urandom_range(0, 3) != 0);
                end else begin
                    in_valid[d]  = 1'b0;
                    out_ready[d] = 1'b1;
                end
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                got = {out_result[d], out_zero[d], out_carry[d], out_overflow[d]};
                if (held[d]) begin
                    chk($sformatf("hold_valid_d%0d", d), out_valid[d], 1);
                    chk($sformatf("hold_value_d%0d", d), got, held_val[d]);
                end
                held[d]     = out_valid[d] && !out_ready[d];
                held_val[d] = got;
                if (out_valid[d] && out_ready[d]) begin
                    sz = (d == 0) ? q0.size() : q1.size();
                    chk($sformatf("sb_nonempty_d%0d", d), (sz != 0), 1);
                    if (sz != 0) begin
                        if (d == 0) exp = q0.pop_front();
                        else        exp = q1.pop_front();
                        chk($sformatf("rand_d%0d", d), got, exp);
                    end
                end
                if (in_valid[d] && in_ready[d]) begin
                    if (d == 0) q0.push_back(ref_alu(in_op[d], in_a[d], in_b[d]));
                    else        q1.push_back(ref_alu(in_op[d], in_a[d], in_b[d]));
                end
            end
        end
        chk("sb_empty_d0", q0.size(), 0);
        chk("sb_empty_d1", q1.size(), 0);
    endtask

    initial begin
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat, nlow, exp_lat;
        vec_t        v;
        logic        seen;

        rst = 1'b1; in_valid = '0; out_ready = '0; in_a = '0; in_b = '0; in_op = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_valid_d%0d", d), out_valid[d], 0);
            chk($sformatf("rst_result_d%0d", d), out_result[d], 0);
            chk($sformatf("rst_flags_d%0d", d), {out_zero[d], out_carry[d], out_overflow[d]}, 0);
            chk($sformatf("rst_in_ready_d%0d", d), in_ready[d], 1);
        end

        // Directed vectors, including flag corners, shift boundaries and serial latency
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 13; i++) begin
                v = get_vec(i);
                run_op(d, v.op, v.a, v.b, res, flg, lat, nlow);
                exp_lat = (d == 1 && v.op >= 4'd5 && v.op <= 4'd7 && v.b[4:0] != 5'd0) ? int'(v.b[4:0]) + 1 : 1;
                chk($sformatf("vec%0d_d%0d_res", i, d), res, v.r);
                chk($sformatf("vec%0d_d%0d_flags", i, d), flg, v.f);
                chk($sformatf("vec%0d_d%0d_latency", i, d), lat, exp_lat);
                chk($sformatf("vec%0d_d%0d_ready_low", i, d), nlow, exp_lat - 1);
            end
        end

        // Backpressure: first ADD result held for 3 cycles, second request waits, then a burst
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            in_valid[d] = 1'b1; in_op[d] = 4'd0; in_a[d] = 32'd10; in_b[d] = 32'd1; out_ready[d] = 1'b0;
            #1;
            chk("bp_first_ready", in_ready[d], 1);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                in_a[d] = 32'd20; in_b[d] = 32'd2;
                #1;
                chk("bp_hold_valid", out_valid[d], 1);
                chk("bp_hold_result", out_result[d], 32'd11);
                chk("bp_in_ready_low", in_ready[d], 0);
            end
            @(negedge clk);
            out_ready[d] = 1'b1;
            #1;
            chk("bp_release_ready", in_ready[d], 1);
            chk("bp_release_result", out_result[d], 32'd11);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (k < 3) begin
                    in_a[d] = 32'd100 + 32'(k); in_b[d] = 32'(k);
                end else begin
                    in_valid[d] = 1'b0;
                end
                #1;
                chk("burst_valid", out_valid[d], 1);
                chk("burst_result", out_result[d], (k == 0) ? 32'd22 : 32'd98 + 32'(2 * k));
            end
            @(negedge clk); #1;
            chk("burst_no_extra", out_valid[d], 0);
        end

        // Reset two cycles into a shamt-20 serial shift discards it
        @(negedge clk);
        in_valid[1] = 1'b1; in_op[1] = 4'd6; in_a[1] = 32'h1; in_b[1] = 32'd20; out_ready = 2'b11;
        #1;
        chk("rs_accept_ready", in_ready[1], 1);
        @(negedge clk);
        in_valid[1] = 1'b0;
        #1;
        chk("rs_busy", in_ready[1], 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rs_valid", out_valid[1], 0);
        chk("rs_result", out_result[1], 0);
        chk("rs_flags", {out_zero[1], out_carry[1], out_overflow[1]}, 0);
        chk("rs_in_ready", in_ready[1], 1);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk); #1;
            if (out_valid[1]) seen = 1'b1;
        end
        chk("rs_no_result", seen, 0);
        run_op(1, 4'd0, 32'd2, 32'd3, res, flg, lat, nlow);
        chk("rs_add_result", res, 32'd5);
        chk("rs_add_latency", lat, 1);

        rand_phase(600, 80);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
